prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: word-address width of the CPU memory; depth = 2**ADDR_WIDTH words.
REQ-002 Parameter RST_HOLD, default 16: CLK cycles cpu_rst is held low after a good load; SHALL be >= 2**`CPU_CLK_DIV_WIDTH.
REQ-003 Parameter SYNC, default 8'h4C: frame start byte.
REQ-004 CLK  input  1  sole clock, all state changes on rising edge.
REQ-005 RST  input  1  synchronous, active-low reset.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts byte; transfer = rx_valid & rx_ready at rising CLK.
REQ-009 mem_addr  output  ADDR_WIDTH  CPU memory write word address.
REQ-010 mem_data  output  16  CPU memory write data.
REQ-011 mem_wr  output  1  one-cycle memory write strobe.
REQ-012 cpu_rst  output  1  active-low CPU reset; low = CPU held.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  last frame loaded and CPU released.
REQ-015 err  output  1  last frame rejected.

Function
REQ-016 Frame: SYNC, LEN_HI, LEN_LO, then LEN words each as hi byte then lo byte, then one checksum byte; LEN = 16-bit word count.
REQ-017 Checksum: 8-bit modulo-256 sum of all bytes after SYNC, including the checksum byte, SHALL equal 8'h00.
REQ-018 States: RUN, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RELEASE, ERROR.
REQ-019 RUN: cpu_rst=1; bytes other than SYNC are accepted and discarded; SYNC -> LEN_HI, clears done/err, checksum, and word counter.
REQ-020 LEN_LO accept: LEN > 2**ADDR_WIDTH -> ERROR; LEN = 0 -> CHECK; else -> DATA_HI.
REQ-021 DATA_HI accept: latch high byte -> DATA_LO.
REQ-022 DATA_LO accept: the next cycle mem_wr=1 for exactly one cycle with mem_addr = word index (0 for the first word, incrementing by 1) and mem_data = {hi, lo}.
REQ-023 DATA_LO accept: after word LEN-1 -> CHECK; otherwise -> DATA_HI.
REQ-024 CHECK accept: sum = 0 -> RELEASE; else -> ERROR.
REQ-025 RELEASE: cpu_rst=0 for exactly RST_HOLD cycles, rx_ready=0, then -> RUN with done=1.
REQ-026 ERROR: err=1; cpu_rst=0 held; rx_ready=1; non-SYNC bytes discarded; SYNC restarts as in REQ-019.
REQ-027 cpu_rst=0 in every state except RUN, from the cycle after SYNC is accepted.
REQ-028 rx_ready=1 in all states except RELEASE.
REQ-029 busy=1 in LEN_HI through RELEASE, else 0.
REQ-030 Words already written before an ERROR remain in memory; no rollback.
REQ-031 rx_valid gaps of any length in mid-frame SHALL NOT alter state; there is no timeout.
REQ-032 A SYNC value received mid-frame is treated as ordinary data/length/checksum.

Reset
REQ-033 RST=0 at a rising edge forces, on the next cycle, state RUN with rx_ready=1, cpu_rst=1, mem_wr=0, mem_addr=0, mem_data=0, busy=0, done=0, err=0.
REQ-034 Reset mid-frame or mid-RELEASE aborts with no further mem_wr; partial memory contents persist.

Verification
REQ-035 Hold RST=0 2 cycles -> all outputs at REQ-033 values; bytes 00, 12 in RUN -> no state change, busy=0.
REQ-036 Send 4C 00 01 F0 00 0F -> single mem_wr with addr 0, data F000; cpu_rst=0 from the cycle after 4C, lasting through RST_HOLD cycles of RELEASE; then cpu_rst=1, done=1, err=0.
REQ-037 Send 4C, LEN=0006, 6 words with 0-3 idle cycles between bytes, correct checksum -> 6 mem_wr pulses, addr 0..5 in order, data matching; done=1.
REQ-038 Send a 2-word frame with checksum off by 1 -> 2 writes occur, then err=1, cpu_rst=0 held; a following valid frame -> err=0, done=1, cpu_rst=1.
REQ-039 Send 4C 00 00 00 -> no mem_wr, RELEASE, done=1; send 4C 04 01 (LEN=1025, ADDR_WIDTH=10) -> ERROR after LEN_LO, no mem_wr.
REQ-040 Assert RST=0 after the 3rd word of a 6-word frame -> no further mem_wr, cpu_rst=1, busy=0, done=0, err=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader.
// Receives a framed program image (SYNC, 16-bit word count, hi/lo data bytes,
// checksum), writes each word into CPU memory and releases the CPU from reset
// only after the whole frame has been received with a good checksum.
module prog_loader #(
  parameter int         ADDR_WIDTH = 10,
  parameter int         RST_HOLD   = 16,
  parameter logic [7:0] SYNC       = 8'h4C
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_wr,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_RUN, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_RELEASE, S_ERROR
  } state_t;

  // Memory depth in words; 17 bits so a 16-bit length can be compared safely.
  localparam logic [16:0] DEPTH  = 17'd1 << ADDR_WIDTH;
  localparam int          HOLD_W = $clog2(RST_HOLD + 1);

  state_t                  state_r;
  logic [15:0]             len_r;
  logic [7:0]              data_hi_r;
  logic [7:0]              sum_r;
  logic [16:0]             word_cnt_r;
  logic [HOLD_W-1:0]       hold_cnt_r;
  logic                    rx_ready_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [15:0]             mem_data_r;
  logic                    mem_wr_r;
  logic                    cpu_rst_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    err_r;

  logic                    accept_s;
  logic [7:0]              sum_next_s;
  logic [15:0]             len_s;

  assign accept_s   = rx_valid & rx_ready_r;
  assign sum_next_s = sum_r + rx_data;
  assign len_s      = {len_r[15:8], rx_data};

  assign rx_ready = rx_ready_r;
  assign mem_addr = mem_addr_r;
  assign mem_data = mem_data_r;
  assign mem_wr   = mem_wr_r;
  assign cpu_rst  = cpu_rst_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

  // Frame-parsing FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r    <= S_RUN;
      len_r      <= 16'h0000;
      data_hi_r  <= 8'h00;
      sum_r      <= 8'h00;
      word_cnt_r <= 17'd0;
      hold_cnt_r <= '0;
      rx_ready_r <= 1'b1;
      mem_addr_r <= '0;
      mem_data_r <= 16'h0000;
      mem_wr_r   <= 1'b0;
      cpu_rst_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      mem_wr_r <= 1'b0;
      case (state_r)
        S_RUN, S_ERROR: begin
          // Non-SYNC bytes are swallowed; SYNC starts a fresh frame.
          if (accept_s && (rx_data == SYNC)) begin
            state_r    <= S_LEN_HI;
            sum_r      <= 8'h00;
            word_cnt_r <= 17'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b1;
            cpu_rst_r  <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (accept_s) begin
            len_r[15:8] <= rx_data;
            sum_r       <= sum_next_s;
            state_r     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            len_r[7:0] <= rx_data;
            sum_r      <= sum_next_s;
            if ({1'b0, len_s} > DEPTH) begin
              // Image larger than memory: reject before any write.
              state_r <= S_ERROR;
              err_r   <= 1'b1;
              busy_r  <= 1'b0;
            end else if (len_s == 16'h0000) begin
              state_r <= S_CHECK;
            end else begin
              state_r <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept_s) begin
            data_hi_r <= rx_data;
            sum_r     <= sum_next_s;
            state_r   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept_s) begin
            sum_r      <= sum_next_s;
            mem_wr_r   <= 1'b1;
            mem_addr_r <= word_cnt_r[ADDR_WIDTH-1:0];
            mem_data_r <= {data_hi_r, rx_data};
            word_cnt_r <= word_cnt_r + 17'd1;
            if ((word_cnt_r + 17'd1) == {1'b0, len_r}) begin
              state_r <= S_CHECK;
            end else begin
              state_r <= S_DATA_HI;
            end
          end
        end
        S_CHECK: begin
          if (accept_s) begin
            if (sum_next_s == 8'h00) begin
              state_r    <= S_RELEASE;
              rx_ready_r <= 1'b0;
              hold_cnt_r <= '0;
            end else begin
              // Words already written stay in memory; CPU stays held.
              state_r <= S_ERROR;
              err_r   <= 1'b1;
              busy_r  <= 1'b0;
            end
          end
        end
        S_RELEASE: begin
          // CPU reset stays asserted for RST_HOLD cycles, then the CPU runs.
          if (hold_cnt_r == HOLD_W'(RST_HOLD - 1)) begin
            state_r    <= S_RUN;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            rx_ready_r <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        default: begin
          state_r    <= S_RUN;
          rx_ready_r <= 1'b1;
          cpu_rst_r  <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frame scenarios plus
// hand-written sequences for reset, release timing and mid-frame reset.
module tb_prog_loader;
  localparam int AW   = 10;
  localparam int HOLD = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_wr;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  prog_loader #(.ADDR_WIDTH(AW), .RST_HOLD(HOLD), .SYNC(8'h4C)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int wr_seen = 0;

  typedef struct { logic [AW-1:0] addr; logic [15:0] data; } exp_wr_t;
  exp_wr_t exp_q[$];

  typedef struct {
    int   len;
    bit   bad;
    int   max_idle;
    bit   sync_word;
    logic exp_done;
    logic exp_err;
    logic exp_cpu_rst;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every memory write must match the oldest expected write.
  always @(negedge CLK) begin : monitor
    exp_wr_t e;
    if (mem_wr === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_wr: got addr %0h data %0h, expected no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_data), 32'(e.data));
      end
    end
  end

  task automatic gap(input int max_idle);
    repeat ($urandom_range(0, max_idle)) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 1000) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 1000) begin
      tests++;
      fails++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit bad, input int max_idle, input bit sync_word);
    logic [15:0] l;
    logic [15:0] w;
    logic [7:0]  sum;
    logic [7:0]  ck;
    exp_wr_t     e;
    l   = 16'(len);
    sum = 8'h00;
    send_byte(8'h4C);           gap(max_idle);
    send_byte(l[15:8]);         gap(max_idle);
    sum = sum + l[15:8];
    send_byte(l[7:0]);          gap(max_idle);
    sum = sum + l[7:0];
    if (len > (1 << AW)) return;
    for (int i = 0; i < len; i++) begin
      w = (sync_word && i == 0) ? 16'h4C4C : 16'($urandom_range(0, 65535));
      send_byte(w[15:8]);       gap(max_idle);
      e.addr = AW'(i);
      e.data = w;
      exp_q.push_back(e);
      send_byte(w[7:0]);        gap(max_idle);
      sum = sum + w[15:8] + w[7:0];
    end
    ck = 8'h00 - sum;
    if (bad) ck = ck + 8'h01;
    send_byte(ck);
  endtask

  task automatic wait_not_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t    vt[7];
    exp_wr_t e;
    int      w0;
    int      exp_w;
    int      n;
    int      low_bad;

    vt[0] = '{1,    1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[1] = '{6,    1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{2,    1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{2,    1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{0,    1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1025, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{3,    1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset held for two cycles.
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_cpu_rst",  32'(cpu_rst),  32'd1);
    check("rst_mem_wr",   32'(mem_wr),   32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Non-SYNC bytes in RUN are discarded.
    send_byte(8'h00);
    check("run_00_busy",    32'(busy),    32'd0);
    check("run_00_cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h12);
    check("run_12_busy",    32'(busy),    32'd0);
    check("run_12_cpu_rst", 32'(cpu_rst), 32'd1);

    // One-word frame with release timing.
    w0 = wr_seen;
    send_byte(8'h4C);
    check("sync_cpu_rst", 32'(cpu_rst), 32'd0);
    check("sync_busy",    32'(busy),    32'd1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hF0);
    e.addr = AW'(0);
    e.data = 16'hF000;
    exp_q.push_back(e);
    send_byte(8'h00);
    send_byte(8'h0F);
    n = 0;
    low_bad = 0;
    while (!rx_ready && n < 200) begin
      if (cpu_rst !== 1'b0) low_bad++;
      @(posedge CLK); #1;
      n++;
    end
    check("release_cycles",  32'(n),       32'(HOLD));
    check("release_cpu_low", 32'(low_bad), 32'd0);
    check("f1_cpu_rst",      32'(cpu_rst), 32'd1);
    check("f1_done",         32'(done),    32'd1);
    check("f1_err",          32'(err),     32'd0);
    check("f1_writes",       32'(wr_seen - w0), 32'd1);

    // Table of frame scenarios.
    for (int i = 0; i < 7; i++) begin
      w0    = wr_seen;
      exp_w = (vt[i].len > (1 << AW)) ? 0 : vt[i].len;
      send_frame(vt[i].len, vt[i].bad, vt[i].max_idle, vt[i].sync_word);
      wait_not_busy($sformatf("v%0d", i));
      repeat (2) @(posedge CLK);
      #1;
      check($sformatf("v%0d_writes", i),   32'(wr_seen - w0),    32'(exp_w));
      check($sformatf("v%0d_pending", i),  32'(exp_q.size()),    32'd0);
      check($sformatf("v%0d_done", i),     32'(done),            32'(vt[i].exp_done));
      check($sformatf("v%0d_err", i),      32'(err),             32'(vt[i].exp_err));
      check($sformatf("v%0d_cpu_rst", i),  32'(cpu_rst),         32'(vt[i].exp_cpu_rst));
      check($sformatf("v%0d_rx_ready", i), 32'(rx_ready),        32'd1);
      exp_q.delete();
    end

    // Reset after the third word of a six-word frame.
    w0 = wr_seen;
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h06);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h21);
      e.addr = AW'(i);
      e.data = {8'h21, 8'(8'h30 + i)};
      exp_q.push_back(e);
      send_byte(8'(8'h30 + i));
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_done",    32'(done),    32'd0);
    check("mid_rst_err",     32'(err),     32'd0);
    check("mid_rst_mem_wr",  32'(mem_wr),  32'd0);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h12);
      send_byte(8'h34);
    end
    send_byte(8'h55);
    repeat (3) @(posedge CLK);
    #1;
    check("mid_rst_writes", 32'(wr_seen - w0), 32'd3);
    check("mid_rst_busy2",  32'(busy),         32'd0);
    check("mid_rst_done2",  32'(done),         32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
